gcd_unit: RTL and testbench

- Multi-cycle GCD coprocessor that responds to the relprime datapath/controller (top_level), which issues a GCD request for each candidate m.
- Returns gcd(a,b), a coprime flag and an iteration count. The controller's relprime loop (n=6930 -> m=13) calls this unit.
- Algorithm is subtractive Euclid, one subtract step per clock, with a start/busy/done handshake.

---
 rtl/gcd_unit.sv | 123 ++++++++++++
 tb/tb_gcd_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_unit.sv
// gcd_unit: multi-cycle subtractive-Euclid GCD coprocessor.
// Ports: CLK, reset (sync, active-high), start, a_in, b_in -> busy, done,
//        result, coprime, iter_count. All outputs are registered.
module gcd_unit #(
   parameter int WIDTH = 16
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             coprime,
   output logic [WIDTH-1:0] iter_count
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_t           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] res_q;
   logic [WIDTH-1:0] iter_q;
   logic             busy_q;
   logic             done_q;
   logic             cop_q;

   logic             a_zero_d;
   logic             b_zero_d;
   logic             eq_d;
   logic             a_gt_d;
   logic             fin_d;
   logic [WIDTH-1:0] a_sub_d;
   logic [WIDTH-1:0] b_sub_d;
   logic [WIDTH-1:0] cnt_d;
   logic [WIDTH-1:0] term_d;

   always_comb begin
      a_zero_d = (a_q == '0);
      b_zero_d = (b_q == '0);
      eq_d     = (a_q == b_q);
      a_gt_d   = (a_q > b_q);
      fin_d    = a_zero_d | b_zero_d | eq_d;
      // Only the larger-minus-smaller difference is ever committed,
      // so neither subtraction can wrap when it is used.
      a_sub_d  = a_q - b_q;
      b_sub_d  = b_q - a_q;
      // Step counter sticks at all-ones instead of wrapping.
      cnt_d    = (&cnt_q) ? cnt_q : cnt_q + ONE;
      // With A==0 the answer sits in B; otherwise A holds it
      // (covers B==0 and A==B alike).
      term_d   = a_zero_d ? b_q : a_q;
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
         iter_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cop_q   <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  a_q     <= a_in;
                  b_q     <= b_in;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_RUN;
               end
            end
            S_RUN: begin
               if (fin_d) begin
                  res_q   <= term_d;
                  cop_q   <= (term_d == ONE);
                  iter_q  <= cnt_q;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  if (a_gt_d) begin
                     a_q <= a_sub_d;
                  end else begin
                     b_q <= b_sub_d;
                  end
                  cnt_q <= cnt_d;
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign result     = res_q;
   assign coprime    = cop_q;
   assign iter_count = iter_q;

endmodule

// File: tb/tb_gcd_unit.sv
// tb_gcd_unit: directed + random checks of gcd_unit against a
// division-based Euclid reference model.
module tb_gcd_unit;

   localparam int W = 16;
   localparam int BUDGET = 70000;

   logic         CLK;
   logic         reset;
   logic         start;
   logic [W-1:0] a_in;
   logic [W-1:0] b_in;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         coprime;
   logic [W-1:0] iter_count;

   int total;
   int bad;

   gcd_unit #(.WIDTH(W)) dut (
      .CLK        (CLK),
      .reset      (reset),
      .start      (start),
      .a_in       (a_in),
      .b_in       (b_in),
      .busy       (busy),
      .done       (done),
      .result     (result),
      .coprime    (coprime),
      .iter_count (iter_count)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Subtractive step count equals the sum of Euclid quotients,
   // minus one for the final exact division (stops at A==B).
   function automatic void ref_gcd(input int unsigned a,
                                   input int unsigned b,
                                   output int unsigned g,
                                   output int unsigned n);
      int unsigned x, y, q, r, t;
      x = a;
      y = b;
      n = 0;
      g = 0;
      if (x == 0 || y == 0) begin
         g = (x == 0) ? y : x;
         return;
      end
      if (x < y) begin
         t = x;
         x = y;
         y = t;
      end
      while (y != 0) begin
         q = x / y;
         r = x % y;
         if (r == 0) begin
            n += q - 1;
            g = y;
            y = 0;
         end else begin
            n += q;
            x = y;
            y = r;
         end
      end
   endfunction

   // Called just after an accepting edge; returns edges until done seen.
   task automatic wait_done(output int edges, output bit bok);
      edges = 0;
      bok = 1'b1;
      for (int k = 0; k < BUDGET; k++) begin
         @(posedge CLK);
         edges++;
         @(negedge CLK);
         if (done === 1'b1) break;
         if (busy !== 1'b1) bok = 1'b0;
      end
   endtask

   // Starts at a negedge, ends at a negedge one cycle after done.
   task automatic do_op(input string tag,
                        input int unsigned a,
                        input int unsigned b,
                        output logic [W-1:0] r_o,
                        output logic c_o,
                        output logic [W-1:0] n_o);
      int edges;
      bit bok;
      int unsigned g, n;
      ref_gcd(a, b, g, n);
      start = 1'b1;
      a_in  = W'(a);
      b_in  = W'(b);
      @(posedge CLK);
      #1 start = 1'b0;
      wait_done(edges, bok);
      r_o = result;
      c_o = coprime;
      n_o = iter_count;
      chk({tag, ".done"}, 32'(done), 32'd1);
      chk({tag, ".result"}, 32'(result), g);
      chk({tag, ".coprime"}, 32'(coprime), 32'(g == 1));
      chk({tag, ".iter"}, 32'(iter_count), n);
      chk({tag, ".latency"}, edges, n + 1);
      chk({tag, ".busy_run"}, 32'(bok), 32'd1);
      chk({tag, ".busy_done"}, 32'(busy), 32'd1);
      @(posedge CLK);
      @(negedge CLK);
      chk({tag, ".done_pulse"}, 32'(done), 32'd0);
      chk({tag, ".busy_idle"}, 32'(busy), 32'd0);
      chk({tag, ".result_hold"}, 32'(result), g);
   endtask

   initial begin
      logic [W-1:0] r, n;
      logic c;
      int edges;
      bit bok;
      bit seen;
      int unsigned ra, rb;

      total = 0;
      bad = 0;
      reset = 1'b1;
      start = 1'b0;
      a_in  = '0;
      b_in  = '0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.done", 32'(done), 32'd0);
      chk("rst.result", 32'(result), 32'd0);
      chk("rst.coprime", 32'(coprime), 32'd0);
      chk("rst.iter", 32'(iter_count), 32'd0);
      reset = 1'b0;
      @(negedge CLK);

      do_op("g6930_2", 6930, 2, r, c, n);
      chk("g6930_2.lit_res", 32'(r), 32'd2);
      chk("g6930_2.lit_iter", 32'(n), 32'd3464);

      do_op("g6930_13", 6930, 13, r, c, n);
      chk("g6930_13.lit_res", 32'(r), 32'd1);
      chk("g6930_13.lit_cop", 32'(c), 32'd1);
      chk("g6930_13.lit_iter", 32'(n), 32'd545);

      do_op("g0_0", 0, 0, r, c, n);
      chk("g0_0.lit_res", 32'(r), 32'd0);
      do_op("g0_7", 0, 7, r, c, n);
      chk("g0_7.lit_res", 32'(r), 32'd7);
      do_op("g1_0", 1, 0, r, c, n);
      chk("g1_0.lit_cop", 32'(c), 32'd1);

      // Start re-asserted during RUN with new operands and then held.
      start = 1'b1;
      a_in  = 16'd6930;
      b_in  = 16'd12;
      @(posedge CLK);
      #1;
      a_in  = 16'd5;
      b_in  = 16'd5;
      wait_done(edges, bok);
      chk("midstart.result", 32'(result), 32'd6);
      chk("midstart.coprime", 32'(coprime), 32'd0);
      chk("midstart.iter", 32'(iter_count), 32'd578);
      chk("midstart.latency", edges, 32'd579);
      chk("midstart.busy", 32'(bok), 32'd1);
      wait_done(edges, bok);
      start = 1'b0;
      chk("held.done", 32'(done), 32'd1);
      chk("held.result", 32'(result), 32'd5);
      chk("held.iter", 32'(iter_count), 32'd0);
      @(posedge CLK);
      @(negedge CLK);
      chk("held.done_pulse", 32'(done), 32'd0);
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("held.no_relaunch", 32'(busy), 32'd0);

      // Reset asserted on edge 100 of a long operation.
      start = 1'b1;
      a_in  = 16'd6930;
      b_in  = 16'd2;
      @(posedge CLK);
      #1 start = 1'b0;
      repeat (99) @(posedge CLK);
      #1 reset = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      chk("abort.busy", 32'(busy), 32'd0);
      chk("abort.done", 32'(done), 32'd0);
      chk("abort.result", 32'(result), 32'd0);
      chk("abort.coprime", 32'(coprime), 32'd0);
      chk("abort.iter", 32'(iter_count), 32'd0);
      reset = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 4000; k++) begin
         @(negedge CLK);
         if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
      end
      chk("abort.quiet", 32'(seen), 32'd0);
      do_op("g9_6", 9, 6, r, c, n);
      chk("g9_6.lit_res", 32'(r), 32'd3);
      chk("g9_6.lit_iter", 32'(n), 32'd2);

      // Relprime search as the controller drives it.
      for (int m = 2; m <= 13; m++) begin
         do_op($sformatf("sweep_m%0d", m), 6930, m, r, c, n);
         chk($sformatf("sweep_m%0d.cop", m), 32'(c), 32'(m == 13));
      end

      for (int i = 0; i < 20; i++) begin
         ra = $urandom_range(0, 400);
         rb = $urandom_range(0, 400);
         do_op($sformatf("rnd%0d_%0d_%0d", i, ra, rb), ra, rb, r, c, n);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
